// File: rtl/btn_pkg.sv
// Shared button indices, vector type and repeat-FSM states for the pushbutton front-end.
package btn_pkg;

  localparam int NBTN  = 5;
  localparam int BTN_C = 4;
  localparam int BTN_L = 3;
  localparam int BTN_R = 2;
  localparam int BTN_U = 1;
  localparam int BTN_D = 0;

  typedef logic [NBTN-1:0] btn_vec_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    RPT   = 2'd2
  } rpt_state_t;

  // Highest-index set bit wins, so C beats L beats R beats U beats D.
  function automatic btn_vec_t onehot_hi(input btn_vec_t v);
    btn_vec_t r;
    r = '0;
    for (int i = 0; i < NBTN; i++) begin
      if (v[i]) begin
        r    = '0;
        r[i] = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_pulse_gen_debounce.sv
// One button: two-flop synchroniser followed by a consecutive-difference debounce counter.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int DB_CYCLES = 3
) (
  input  logic clkBTN,
  input  logic rst,
  input  logic raw,
  output logic db
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  logic          sync_p0;
  logic          sync_p1;
  logic [CW-1:0] cnt;

  // Stage p0/p1: synchroniser; then debounce against the current stable level.
  always_ff @(posedge clkBTN or posedge rst) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      cnt     <= '0;
      db      <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      if (sync_p1 == db) begin
        cnt <= '0;
      end else if (cnt == CW'(DB_CYCLES)) begin
        db  <= sync_p1;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/btn_pulse_gen.sv
// Pushbutton front-end: debounce, rising-edge pulses and one-hot arbitration on clkBTN.
// Define BTN_AUTO_REPEAT_EN to auto-repeat U/D while held.
module btn_pulse_gen
  import btn_pkg::*;
#(
  parameter int DB_CYCLES    = 3,
  parameter int REPEAT_DELAY = 25,
  parameter int REPEAT_RATE  = 5
) (
  input  logic clkBTN,
  input  logic rst,
  input  logic btnC,
  input  logic btnL,
  input  logic btnR,
  input  logic btnU,
  input  logic btnD,
  output logic C,
  output logic L,
  output logic R,
  output logic U,
  output logic D,
  output logic held
);

  btn_vec_t raw;
  btn_vec_t db;
  btn_vec_t db_p1;
  btn_vec_t rise;
  btn_vec_t rpt_fire;
  btn_vec_t cand;
  btn_vec_t pulse_p2;

  assign raw = {btnC, btnL, btnR, btnU, btnD};

  for (genvar i = 0; i < NBTN; i++) begin : g_db
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clkBTN (clkBTN),
      .rst    (rst),
      .raw    (raw[i]),
      .db     (db[i])
    );
  end

  assign rise = db & ~db_p1;
  assign cand = rise | rpt_fire;

  // Stage p1: edge history; stage p2: arbitrated output register.
  always_ff @(posedge clkBTN or posedge rst) begin
    if (rst) begin
      db_p1    <= '0;
      pulse_p2 <= '0;
    end else begin
      db_p1    <= db;
      pulse_p2 <= onehot_hi(cand);
    end
  end

  assign {C, L, R, U, D} = pulse_p2;
  assign held = |db;

`ifdef BTN_AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX);

  rpt_state_t    state;
  logic [RW-1:0] rcnt;
  logic          sel_u;
  logic          sel_db;
  logic          cancel;
  logic          fire;

  assign sel_db = sel_u ? db[BTN_U] : db[BTN_D];
  // Leaving repeat mode suppresses any fire due in the same cycle.
  assign cancel = (state != IDLE) && (!sel_db || (|rise[BTN_C:BTN_R]));
  assign fire   = !cancel &&
                  (((state == DELAY) && (rcnt == RW'(REPEAT_DELAY - 1))) ||
                   ((state == RPT)   && (rcnt == RW'(REPEAT_RATE - 1))));

  always_comb begin
    rpt_fire        = '0;
    rpt_fire[BTN_U] = fire & sel_u;
    rpt_fire[BTN_D] = fire & ~sel_u;
  end

  always_ff @(posedge clkBTN or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rcnt  <= '0;
      sel_u <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rise[BTN_U] || rise[BTN_D]) begin
            state <= DELAY;
            rcnt  <= '0;
            sel_u <= rise[BTN_U];
          end
        end
        DELAY, RPT: begin
          if (cancel) begin
            state <= IDLE;
            rcnt  <= '0;
          end else if (fire) begin
            state <= RPT;
            rcnt  <= '0;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          rcnt  <= '0;
        end
      endcase
    end
  end
`else
  assign rpt_fire = '0;
`endif

endmodule

// File: doc/btn_pulse_gen.md
Name: btn_pulse_gen

Overview:
Front-end that produces the button pulses the alarm-clock counter/state logic consumes on clkBTN. It conditions the five raw pushbuttons (C, L, R, U, D) in four stages: two-flop synchronisation, per-button debounce, rising-edge pulse generation and one-hot arbitration. The result is clean single-cycle pulses, of which at most one is asserted per cycle. It optionally auto-repeats U/D while held, for fast hour/minute adjustment.

Parameters:
DB_CYCLES, 3, consecutive clkBTN cycles a synchronised input must differ from the debounced state before that state flips (min 1)
REPEAT_DELAY, 25, cycles from the initial U/D pulse to the first repeat pulse (min 2)
REPEAT_RATE, 5, cycles between successive repeat pulses (min 2)

Ports:
clkBTN  input  1  button-domain clock; all state on posedge
rst  input  1  asynchronous, active-high reset
btnC  input  1  raw centre button, asynchronous, bouncy
btnL  input  1  raw left button
btnR  input  1  raw right button
btnU  input  1  raw up button
btnD  input  1  raw down button
C  output  1  registered single-cycle press pulse, centre
L  output  1  press pulse, left
R  output  1  press pulse, right
U  output  1  press pulse/repeat, up
D  output  1  press pulse/repeat, down
held  output  1  OR of all five debounced levels

Behaviour:
- Reset: rst is asynchronous, active-high; the clock is clkBTN. On rst, all synchronisers, debounced levels, counters, FSM and outputs go to 0. Outputs are 0 while rst is high.
- Synchroniser: 2 FFs per button.
- Debounce, per button: counter clears whenever sync == db. When sync != db, the counter increments. On the cycle the count reaches DB_CYCLES, db <= sync and the counter clears. Counter width is clog2(DB_CYCLES+1).
- Edge: rise[i] = db[i] & ~db_q[i], where db_q is db delayed one cycle. Falling edges produce nothing.
- Latency: a raw level stable from cycle 0 produces its output pulse at cycle 2+DB_CYCLES+1.
- Candidate vector: cand = rise | rpt_fire. Priority is C > L > R > U > D. The output register loads the one-hot of the highest set bit. Lower candidates in the same cycle are dropped, not queued.
- Outputs are registered, high exactly one cycle per accepted event. {C,L,R,U,D} is always one-hot or zero.
- A press of another button while one is held is accepted normally.
- A button held through rst deassertion is treated as a new press and yields one pulse after debounce latency.
- held = |db (combinational from registers), reset 0.

Optional Feature:
Macro: BTN_AUTO_REPEAT_EN
- Defined: a shared repeat FSM with states IDLE, DELAY, RPT.
  - Counter clears on every state entry. sel records U or D.
  - IDLE -> DELAY on rise[U] or rise[D]. If both rise together, sel = U.
  - DELAY: after REPEAT_DELAY cycles, assert rpt_fire[sel] for 1 cycle and go to RPT.
  - RPT: assert rpt_fire[sel] every REPEAT_RATE cycles.
  - Any state -> IDLE when db[sel] falls, or when rise of C, L or R occurs. In that case no repeat fires that cycle.
  - A repeat fire can lose arbitration to a same-cycle C/L/R rise; such a fire is dropped.
- Undefined: no FSM; rpt_fire = 0. Each press gives exactly one pulse regardless of hold length.

Decomposition:
- Shared package btn_pkg:
  - button index constants BTN_C=4, BTN_L=3, BTN_R=2, BTN_U=1, BTN_D=0
  - 5-bit button-vector typedef
  - repeat-FSM state enum (IDLE=2'd0, DELAY=2'd1, RPT=2'd2)
- Sub-module btn_debounce (sync + debounce counter, param DB_CYCLES, outputs db), instantiated 5 times.
- Arbitration and repeat FSM live in the top.

Test Plan:
- btnC toggles 1,0,1,0 on consecutive cycles then holds 1 at cycle 4 (DB_CYCLES=3) -> exactly one C pulse, at cycle 4+6=10; no other outputs; held=1 from cycle 9.
- btnR high for 2 cycles then low (DB_CYCLES=3) -> no R pulse, held stays 0.
- btnL and btnU stable high from the same cycle -> single L pulse; U never pulses for that press (macro undefined). With macro defined, U repeat pulses still start REPEAT_DELAY after the dropped rise.
- Macro defined, btnU held 45 cycles (DELAY=25, RATE=5) -> U pulses at t0, t0+25, +30, +35, ... until db falls; none afterwards.
- Macro defined, btnD held, rst pulsed in DELAY state -> outputs 0 immediately; after rst release, D produces one fresh pulse after 2+DB_CYCLES+1 cycles, then repeats after REPEAT_DELAY.
- Macro undefined, btnD held 100 cycles -> exactly one D pulse; all five outputs never simultaneously >1 bit set (assertion over full run).
